// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-queue entry type.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_WIDTH  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_WIDTH-1:0]  data;
  } wq_entry_t;

endpackage

// File: rtl/regfile_write_queue_fwd_match.sv
// Youngest-match lookup over the occupied queue entries for one read port.
module wq_fwd_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wq_entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]       valid,
  input  logic [PTR_W-1:0]       head,
  input  logic [REG_ADDR_W-1:0]  rd_addr,
  output logic                   hit,
  output logic [REG_WIDTH-1:0]   data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (entries[idx].addr == rd_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write-back buffer in front of a single-write-port register file,
// with youngest-entry forwarding onto both read ports.
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = REG_WIDTH,
  parameter int ADDR_W = REG_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              hold,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [WIDTH-1:0]  writeData,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [WIDTH-1:0]  rf_data1,
  input  logic [WIDTH-1:0]  rf_data2,
  output logic [WIDTH-1:0]  fwd_data1,
  output logic [WIDTH-1:0]  fwd_data2,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  // Handshake: a request transfers at a rising edge where wb_valid and
  // wb_ready are both high; wb_ready is a function of occupancy and reset
  // only, so the producer may hold wb_valid until it sees ready.

  wq_entry_t        entries_q [DEPTH];
  wq_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [DEPTH-1:0] valid_mask;
  logic [PTR_W-1:0] offset;
  logic             hit1, hit2;
  logic [WIDTH-1:0] match_data1, match_data2;

  assign wb_ready      = reset_n && (count_q < CNT_W'(DEPTH));
  assign regWrite      = reset_n && (count_q != '0) && !hold;
  assign writeRegister = entries_q[rd_ptr_q].addr;
  assign writeData     = entries_q[rd_ptr_q].data;
  assign count         = count_q;
  assign empty         = (count_q == '0);

  // Writes to r0 complete the handshake but never occupy an entry.
  assign push = wb_valid && wb_ready && (wb_addr != REG_ZERO);
  assign pop  = regWrite;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    entries_d = entries_q;
    if (push) begin
      entries_d[wr_ptr_q] = '{addr: wb_addr, data: wb_data};
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  // Slot i is occupied when its distance from the head is below count.
  always_comb begin
    valid_mask = '0;
    offset     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rd_ptr_q;
      valid_mask[i] = ({1'b0, offset} < count_q);
    end
  end

  wq_fwd_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (entries_q),
    .valid   (valid_mask),
    .head    (rd_ptr_q),
    .rd_addr (rd_addr1),
    .hit     (hit1),
    .data    (match_data1)
  );

  wq_fwd_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (entries_q),
    .valid   (valid_mask),
    .head    (rd_ptr_q),
    .rd_addr (rd_addr2),
    .hit     (hit2),
    .data    (match_data2)
  );

  assign fwd_data1 = (rd_addr1 == REG_ZERO) ? '0 : (hit1 ? match_data1 : rf_data1);
  assign fwd_data2 = (rd_addr2 == REG_ZERO) ? '0 : (hit2 ? match_data2 : rf_data2);

endmodule
